// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the uart_tx arbiter: FSM state encoding and default lock timeout.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

  // 1 ms at 48 MHz
  localparam int unsigned LOCK_TIMEOUT_DEFAULT = 32'd48000;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above ptr, wrapping modulo N_REQ.
module uart_tx_arbiter_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             found,
  output logic [ID_W-1:0]  idx
);

  logic [ID_W:0]   cand_s;
  logic [ID_W-1:0] cand_idx_s;

  // Scan from the farthest candidate down so the nearest one to ptr overwrites the rest
  always_comb begin
    found      = 1'b0;
    idx        = '0;
    cand_s     = '0;
    cand_idx_s = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand_s = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand_s >= (ID_W+1)'(N_REQ)) begin
        cand_s = cand_s - (ID_W+1)'(N_REQ);
      end else begin
        cand_s = cand_s;
      end
      cand_idx_s = cand_s[ID_W-1:0];
      if (req[cand_idx_s]) begin
        found = 1'b1;
        idx   = cand_idx_s;
      end else begin
        found = found;
        idx   = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locking arbiter sharing one uart_tx between N_REQ requesters.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int ID_W         = 2,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEFAULT
) (
  input  logic                 clk_48,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  input  logic                 uart_ready,
  output logic [7:0]           uart_data,
  output logic                 uart_strobe,
  output logic [ID_W-1:0]      grant_id,
  output logic                 locked,
  output logic                 lock_timeout
);

  localparam int CNT_W = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;

  arb_state_e       state_r, state_s;
  logic [ID_W-1:0]  rr_ptr_r, rr_ptr_s;
  logic [ID_W-1:0]  grant_id_r, grant_id_s;
  logic             locked_r, locked_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [7:0]       uart_data_r, uart_data_s;
  logic             uart_strobe_r, uart_strobe_s;
  logic [N_REQ-1:0] req_ready_r, req_ready_s;
  logic             lock_timeout_r, lock_timeout_s;
  logic             pick_found_s;
  logic [ID_W-1:0]  pick_idx_s;

  function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] i);
    if (i == ID_W'(N_REQ - 1)) begin
      return '0;
    end else begin
      return i + ID_W'(1);
    end
  endfunction

  uart_tx_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_r),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // Next-state and next-output logic; pulses and the timeout counter default to cleared
  always_comb begin
    state_s        = state_r;
    rr_ptr_s       = rr_ptr_r;
    grant_id_s     = grant_id_r;
    locked_s       = locked_r;
    cnt_s          = '0;
    uart_data_s    = uart_data_r;
    uart_strobe_s  = 1'b0;
    req_ready_s    = '0;
    lock_timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (locked_r) begin
          if (req_valid[grant_id_r]) begin
            if (uart_ready) begin
              state_s = ST_ISSUE;
            end else begin
              state_s = ST_IDLE;
            end
          end else if (cnt_r == CNT_W'(LOCK_TIMEOUT - 1)) begin
            // Owner went silent mid-message: release so others are not starved
            locked_s       = 1'b0;
            rr_ptr_s       = next_idx(grant_id_r);
            lock_timeout_s = 1'b1;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else if (uart_ready && pick_found_s) begin
          grant_id_s = pick_idx_s;
          state_s    = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        uart_data_s             = req_data[{grant_id_r, 3'b000} +: 8];
        uart_strobe_s           = 1'b1;
        req_ready_s[grant_id_r] = 1'b1;
        if (req_last[grant_id_r]) begin
          locked_s = 1'b0;
          rr_ptr_s = next_idx(grant_id_r);
        end else begin
          locked_s = 1'b1;
        end
        state_s = ST_HOLD;
      end
      // uart_ready may still read high for one cycle after the strobe
      ST_HOLD: begin
        state_s = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (uart_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_48) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      rr_ptr_r       <= '0;
      grant_id_r     <= '0;
      locked_r       <= 1'b0;
      cnt_r          <= '0;
      uart_data_r    <= 8'h00;
      uart_strobe_r  <= 1'b0;
      req_ready_r    <= '0;
      lock_timeout_r <= 1'b0;
    end else begin
      state_r        <= state_s;
      rr_ptr_r       <= rr_ptr_s;
      grant_id_r     <= grant_id_s;
      locked_r       <= locked_s;
      cnt_r          <= cnt_s;
      uart_data_r    <= uart_data_s;
      uart_strobe_r  <= uart_strobe_s;
      req_ready_r    <= req_ready_s;
      lock_timeout_r <= lock_timeout_s;
    end
  end

  assign req_ready    = req_ready_r;
  assign uart_data    = uart_data_r;
  assign uart_strobe  = uart_strobe_r;
  assign grant_id     = grant_id_r;
  assign locked       = locked_r;
  assign lock_timeout = lock_timeout_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: scripted requesters, a simple uart_tx busy model, immediate-assert checks.
module tb_uart_tx_arbiter;

  localparam int LT    = 200;
  localparam int FRAME = 10;

  logic        clk_48 = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        uart_ready;
  logic [7:0]  uart_data;
  logic        uart_strobe;
  logic [1:0]  grant_id;
  logic        locked;
  logic        lock_timeout;

  logic model_ready = 1'b1;
  logic force_low   = 1'b0;
  assign uart_ready = model_ready && !force_low;

  typedef struct {
    logic [7:0] data;
    logic [1:0] gid;
    logic [3:0] rdy;
    logic       lck;
    int         cyc;
  } ev_t;

  ev_t        log_q[$];
  logic [7:0] m_data [4][8];
  logic       m_last [4][8];
  int         m_len [4];
  int         m_pos [4];
  int         cyc = 0;
  int         busy = 0;
  int         rdy_cycles = 0;
  int         to_pulses = 0;
  int         to_cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  int         base;
  int         t;

  uart_tx_arbiter #(
    .N_REQ        (4),
    .ID_W         (2),
    .LOCK_TIMEOUT (LT)
  ) dut (
    .clk_48       (clk_48),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .uart_ready   (uart_ready),
    .uart_data    (uart_data),
    .uart_strobe  (uart_strobe),
    .grant_id     (grant_id),
    .locked       (locked),
    .lock_timeout (lock_timeout)
  );

  always #5 clk_48 = ~clk_48;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Requesters, uart_tx busy model and event log, all updated on the falling edge
  initial begin
    forever begin
      @(negedge clk_48);
      cyc++;
      if (uart_strobe) begin
        log_q.push_back('{uart_data, grant_id, req_ready, locked, cyc});
        busy = FRAME;
      end else if (busy != 0) begin
        busy--;
      end
      model_ready = (busy == 0);
      if (req_ready != 4'b0000) rdy_cycles++;
      if (lock_timeout) begin
        to_pulses++;
        to_cyc = cyc;
      end
      for (int i = 0; i < 4; i++) begin
        if (req_ready[i]) m_pos[i]++;
        if (m_pos[i] < m_len[i]) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = m_data[i][m_pos[i]];
          req_last[i]        = m_last[i][m_pos[i]];
        end else begin
          req_valid[i]       = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_msg(input int r, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input int n, input bit all_last);
    m_data[r][0] = b0;
    m_data[r][1] = b1;
    m_data[r][2] = b2;
    for (int k = 0; k < 8; k++) m_last[r][k] = all_last || (k == n - 1);
    m_pos[r] = 0;
    m_len[r] = n;
  endtask

  task automatic clear_reqs();
    for (int r = 0; r < 4; r++) begin
      m_len[r] = 0;
      m_pos[r] = 0;
    end
  endtask

  task automatic reset_on();
    @(negedge clk_48);
    reset = 1'b1;
    clear_reqs();
    @(negedge clk_48);
    log_q.delete();
    rdy_cycles = 0;
    to_pulses  = 0;
  endtask

  task automatic reset_off();
    @(negedge clk_48);
    reset = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int k = 0;
    while (log_q.size() < n && k < budget) begin
      @(negedge clk_48);
      k++;
    end
    chk(tag, log_q.size(), n);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_req_ready"}, {28'd0, req_ready}, 32'h0);
    chk({pfx, "_uart_data"}, {24'd0, uart_data}, 32'h0);
    chk({pfx, "_strobe"}, {31'd0, uart_strobe}, 32'h0);
    chk({pfx, "_grant_id"}, {30'd0, grant_id}, 32'h0);
    chk({pfx, "_locked"}, {31'd0, locked}, 32'h0);
    chk({pfx, "_lock_timeout"}, {31'd0, lock_timeout}, 32'h0);
  endtask

  logic [1:0] exp_gid [6];
  logic [7:0] exp_dat [6];
  logic       exp_lck [6];

  initial begin
    reset = 1'b1;
    clear_reqs();
    for (int r = 0; r < 4; r++) for (int k = 0; k < 8; k++) begin
      m_data[r][k] = 8'h00;
      m_last[r][k] = 1'b0;
    end
    repeat (3) @(negedge clk_48);
    chk_reset_outputs("rst0");
    reset_off();

    // Requester 0 sends CR LF 'A' as one message
    set_msg(0, 8'h0D, 8'h0A, 8'h41, 3, 1'b0);
    wait_log(3, 500, "t1_count");
    exp_dat = '{8'h0D, 8'h0A, 8'h41, 8'h00, 8'h00, 8'h00};
    exp_lck = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t1_data%0d", i), {24'd0, log_q[i].data}, {24'd0, exp_dat[i]});
      chk($sformatf("t1_rdy%0d", i), {28'd0, log_q[i].rdy}, 32'h1);
      chk($sformatf("t1_lock%0d", i), {31'd0, log_q[i].lck}, {31'd0, exp_lck[i]});
    end
    chk("t1_rdy_cycles", rdy_cycles, 3);

    // Requesters 1 and 2 both pending from reset; message 1 must complete first
    reset_on();
    set_msg(1, 8'h61, 8'h62, 8'h63, 3, 1'b0);
    set_msg(2, 8'h64, 8'h65, 8'h66, 3, 1'b0);
    reset_off();
    wait_log(6, 1000, "t2_count");
    exp_gid = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
    exp_dat = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t2_gid%0d", i), {30'd0, log_q[i].gid}, {30'd0, exp_gid[i]});
      chk($sformatf("t2_data%0d", i), {24'd0, log_q[i].data}, {24'd0, exp_dat[i]});
    end
    chk("t2_rdy3", {28'd0, log_q[3].rdy}, 32'h4);

    // All four requesters stream single-byte messages
    reset_on();
    for (int r = 0; r < 4; r++) set_msg(r, 8'(8'h10 * r), 8'(8'h10 * r + 1), 8'h00, 2, 1'b1);
    reset_off();
    wait_log(6, 1000, "t3_count");
    exp_gid = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp_dat = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01, 8'h11};
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t3_gid%0d", i), {30'd0, log_q[i].gid}, {30'd0, exp_gid[i]});
      chk($sformatf("t3_data%0d", i), {24'd0, log_q[i].data}, {24'd0, exp_dat[i]});
      chk($sformatf("t3_lock%0d", i), {31'd0, log_q[i].lck}, 32'h0);
    end
    wait_log(8, 500, "t3_drain");

    // Requester 3 opens a message and goes silent; requester 0 waits behind the lock
    reset_on();
    reset_off();
    set_msg(3, 8'h58, 8'h00, 8'h00, 1, 1'b0);
    set_msg(3, 8'h58, 8'h00, 8'h00, 1, 1'b0);
    m_last[3][0] = 1'b0;
    wait_log(1, 300, "t4_first");
    chk("t4_lock_x", {31'd0, log_q[0].lck}, 32'h1);
    set_msg(0, 8'h59, 8'h00, 8'h00, 1, 1'b0);
    t = 0;
    while (to_pulses == 0 && t < FRAME + LT + 100) begin
      @(negedge clk_48);
      t++;
    end
    wait_log(2, 300, "t4_second");
    chk("t4_to_delay", to_cyc - log_q[0].cyc, FRAME + LT + 1);
    chk("t4_to_pulses", to_pulses, 1);
    chk("t4_gid", {30'd0, log_q[1].gid}, 32'h0);
    chk("t4_data", {24'd0, log_q[1].data}, 32'h59);
    chk("t4_after_to", {31'd0, (log_q[1].cyc > to_cyc)}, 32'h1);

    // uart_tx held busy: nothing may be issued until it becomes ready
    reset_on();
    force_low = 1'b1;
    reset_off();
    set_msg(0, 8'h5A, 8'h00, 8'h00, 1, 1'b0);
    repeat (1000) @(negedge clk_48);
    chk("t5_no_strobe", log_q.size(), 0);
    chk("t5_no_ready", rdy_cycles, 0);
    force_low = 1'b0;
    @(negedge clk_48);
    chk("t5_strobe_c1", {31'd0, uart_strobe}, 32'h0);
    @(negedge clk_48);
    chk("t5_strobe_c2", {31'd0, uart_strobe}, 32'h1);
    chk("t5_ready_c2", {28'd0, req_ready}, 32'h1);
    chk("t5_data_c2", {24'd0, uart_data}, 32'h5A);

    // Reset while draining a locked message from requester 2
    reset_on();
    reset_off();
    set_msg(2, 8'h6D, 8'h6E, 8'h6F, 3, 1'b0);
    t = 0;
    while (uart_strobe !== 1'b1 && t < 300) begin
      @(negedge clk_48);
      t++;
    end
    @(negedge clk_48);
    chk("t6_locked_pre", {31'd0, locked}, 32'h1);
    chk("t6_gid_pre", {30'd0, grant_id}, 32'h2);
    reset = 1'b1;
    set_msg(0, 8'h51, 8'h00, 8'h00, 1, 1'b0);
    @(negedge clk_48);
    chk_reset_outputs("t6_rst");
    base = log_q.size();
    reset = 1'b0;
    wait_log(base + 1, 300, "t6_next");
    chk("t6_gid_next", {30'd0, log_q[base].gid}, 32'h0);
    chk("t6_data_next", {24'd0, log_q[base].data}, 32'h51);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
